// File: rtl/clock_display_scanner_pkg.sv
// Shared definitions for the clock display scanner: page encodings, segment
// constants and the BCD-to-7-segment decoder (active-low, {g..a}).
package clock_display_pkg;

   typedef enum logic [1:0] {
      PG_HM = 2'd0,
      PG_MS = 2'd1,
      PG_MD = 2'd2,
      PG_CY = 2'd3
   } page_e;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'h3F;

   // Anything that is not valid BCD shows a dash so a corrupt digit is visible.
   function automatic logic [6:0] bcdToSeg(input logic [3:0] bcd);
      logic [6:0] segVal;
      case (bcd)
         4'd0:    segVal = 7'h40;
         4'd1:    segVal = 7'h79;
         4'd2:    segVal = 7'h24;
         4'd3:    segVal = 7'h30;
         4'd4:    segVal = 7'h19;
         4'd5:    segVal = 7'h12;
         4'd6:    segVal = 7'h02;
         4'd7:    segVal = 7'h78;
         4'd8:    segVal = 7'h00;
         4'd9:    segVal = 7'h10;
         default: segVal = SEG_DASH;
      endcase
      return segVal;
   endfunction

endpackage

// File: rtl/clock_display_scanner_debouncer.sv
// Pushbutton conditioner: 2-FF synchronizer, stability counter and a one-cycle
// pulse on the rising edge of the debounced level.
module button_debouncer #(
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic btn_i,
   output logic rise_o
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q, sync2_q;
   logic          level_q, level_d;
   logic          rise_q, rise_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // The level only follows the input after DEBOUNCE_CYCLES consecutive
   // disagreeing samples; any agreeing sample restarts the count.
   always_comb begin
      level_d = level_q;
      rise_d  = 1'b0;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = sync2_q;
            rise_d  = sync2_q;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= btn_i;
         sync2_q <= sync1_q;
         level_q <= level_d;
         rise_q  <= rise_d;
         cnt_q   <= cnt_d;
      end
   end

   assign rise_o = rise_q;

endmodule

// File: rtl/clock_display_scanner.sv
// Drives the 4-digit active-low 7-segment display from the clock/calendar
// digits: digit multiplexing, page selection, colon blink and AM/PM point.
module clock_display_scanner
   import clock_display_pkg::*;
#(
   parameter int REFRESH_DIV     = 100000,
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic       clk_100MHz,
   input  logic       reset,
   input  logic       tick_1Hz,
   input  logic       am_pm,
   input  logic [3:0] hr_10s,
   input  logic [3:0] hr_1s,
   input  logic [3:0] min_10s,
   input  logic [3:0] min_1s,
   input  logic [3:0] sec_10s,
   input  logic [3:0] sec_1s,
   input  logic [3:0] m_10s,
   input  logic [3:0] m_1s,
   input  logic [3:0] d_10s,
   input  logic [3:0] d_1s,
   input  logic [3:0] y_10s,
   input  logic [3:0] y_1s,
   input  logic [3:0] c_10s,
   input  logic [3:0] c_1s,
   input  logic       btn_page,
   output logic [6:0] seg,
   output logic       dp,
   output logic [3:0] an,
   output logic [1:0] page
);

   localparam int RW = $clog2(REFRESH_DIV);
   localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);

   logic [RW-1:0] refreshCnt_q, refreshCnt_d;
   logic [1:0]    digitIdx_q, digitIdx_d;
   page_e         page_q, page_d;
   logic          blink_q, blink_d;
   logic [6:0]    seg_q, seg_d;
   logic          dp_q, dp_d;
   logic [3:0]    an_q, an_d;
   logic          pageRise;
   logic [3:0]    digit;
   logic          dpLit;

   button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) uPageBtn (
      .clk_i  (clk_100MHz),
      .reset_i(reset),
      .btn_i  (btn_page),
      .rise_o (pageRise)
   );

   always_comb begin
      refreshCnt_d = refreshCnt_q + RW'(1);
      digitIdx_d   = digitIdx_q;
      if (refreshCnt_q == REFRESH_LAST) begin
         refreshCnt_d = '0;
         digitIdx_d   = digitIdx_q + 2'd1;
      end
      blink_d = blink_q ^ tick_1Hz;
   end

   // Page FSM: one step per debounced press, wrapping from CCYY back to HH:MM.
   always_comb begin
      page_d = page_q;
      if (pageRise) begin
         unique case (page_q)
            PG_HM: page_d = PG_MS;
            PG_MS: page_d = PG_MD;
            PG_MD: page_d = PG_CY;
            PG_CY: page_d = PG_HM;
         endcase
      end
   end

   always_comb begin
      digit = '0;
      dpLit = 1'b0;
      unique case (page_q)
         PG_HM: begin
            unique case (digitIdx_q)
               2'd0: digit = min_1s;
               2'd1: digit = min_10s;
               2'd2: digit = hr_1s;
               2'd3: digit = hr_10s;
            endcase
            dpLit = ((digitIdx_q == 2'd2) && blink_q) || ((digitIdx_q == 2'd0) && am_pm);
         end
         PG_MS: begin
            unique case (digitIdx_q)
               2'd0: digit = sec_1s;
               2'd1: digit = sec_10s;
               2'd2: digit = min_1s;
               2'd3: digit = min_10s;
            endcase
            dpLit = (digitIdx_q == 2'd2) && blink_q;
         end
         PG_MD: begin
            unique case (digitIdx_q)
               2'd0: digit = d_1s;
               2'd1: digit = d_10s;
               2'd2: digit = m_1s;
               2'd3: digit = m_10s;
            endcase
            dpLit = (digitIdx_q == 2'd2);
         end
         PG_CY: begin
            unique case (digitIdx_q)
               2'd0: digit = y_1s;
               2'd1: digit = y_10s;
               2'd2: digit = c_1s;
               2'd3: digit = c_10s;
            endcase
         end
      endcase

      seg_d = bcdToSeg(digit);
      // Only the hours tens digit is suppressed, so " 9:05" rather than "09:05".
      if ((page_q == PG_HM) && (digitIdx_q == 2'd3) && (hr_10s == 4'd0)) begin
         seg_d = SEG_BLANK;
      end
      dp_d = ~dpLit;
      an_d = ~(4'b0001 << digitIdx_q);
   end

   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) begin
         refreshCnt_q <= '0;
         digitIdx_q   <= 2'd0;
         page_q       <= PG_HM;
         blink_q      <= 1'b0;
         seg_q        <= SEG_BLANK;
         dp_q         <= 1'b1;
         an_q         <= 4'hF;
      end else begin
         refreshCnt_q <= refreshCnt_d;
         digitIdx_q   <= digitIdx_d;
         page_q       <= page_d;
         blink_q      <= blink_d;
         seg_q        <= seg_d;
         dp_q         <= dp_d;
         an_q         <= an_d;
      end
   end

   assign seg  = seg_q;
   assign dp   = dp_q;
   assign an   = an_q;
   assign page = page_q;

endmodule

// File: tb/tb_clock_display_scanner.sv
// Randomized bench for clock_display_scanner against a cycle-level reference
// model built from the display rules (slot arithmetic, sample-window debounce).
module tb_clock_display_scanner;

   localparam int REFRESH_DIV     = 4;
   localparam int DEBOUNCE_CYCLES = 8;

   logic       clk_100MHz = 1'b0;
   logic       reset      = 1'b0;
   logic       tick_1Hz   = 1'b0;
   logic       am_pm      = 1'b0;
   logic [3:0] hr_10s = '0, hr_1s = '0, min_10s = '0, min_1s = '0;
   logic [3:0] sec_10s = '0, sec_1s = '0;
   logic [3:0] m_10s = '0, m_1s = '0, d_10s = '0, d_1s = '0;
   logic [3:0] y_10s = '0, y_1s = '0, c_10s = '0, c_1s = '0;
   logic       btn_page = 1'b0;
   logic [6:0] seg;
   logic       dp;
   logic [3:0] an;
   logic [1:0] page;

   int checks   = 0;
   int failures = 0;

   int edgeCount    = 0;
   int mPage        = 0;
   bit mBlink       = 1'b0;
   bit mLevel       = 1'b0;
   bit mRisePending = 1'b0;
   bit btnHist[$];
   int btnLeft      = 0;

   clock_display_scanner #(
      .REFRESH_DIV    (REFRESH_DIV),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) dut (
      .clk_100MHz(clk_100MHz),
      .reset     (reset),
      .tick_1Hz  (tick_1Hz),
      .am_pm     (am_pm),
      .hr_10s    (hr_10s),
      .hr_1s     (hr_1s),
      .min_10s   (min_10s),
      .min_1s    (min_1s),
      .sec_10s   (sec_10s),
      .sec_1s    (sec_1s),
      .m_10s     (m_10s),
      .m_1s      (m_1s),
      .d_10s     (d_10s),
      .d_1s      (d_1s),
      .y_10s     (y_10s),
      .y_1s      (y_1s),
      .c_10s     (c_10s),
      .c_1s      (c_1s),
      .btn_page  (btn_page),
      .seg       (seg),
      .dp        (dp),
      .an        (an),
      .page      (page)
   );

   always #5 clk_100MHz = ~clk_100MHz;

   task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s at t=%0t: got %h, want %h", tag, $time, observed, expected);
      end
   endtask

   function automatic logic [6:0] segOf(input logic [3:0] d);
      case (d)
         4'd0:    return 7'h40;
         4'd1:    return 7'h79;
         4'd2:    return 7'h24;
         4'd3:    return 7'h30;
         4'd4:    return 7'h19;
         4'd5:    return 7'h12;
         4'd6:    return 7'h02;
         4'd7:    return 7'h78;
         4'd8:    return 7'h00;
         4'd9:    return 7'h10;
         default: return 7'h3F;
      endcase
   endfunction

   function automatic logic [3:0] randDigit();
      if ($urandom_range(0, 7) == 0) return 4'($urandom_range(10, 15));
      return 4'($urandom_range(0, 9));
   endfunction

   task automatic modelReset();
      edgeCount    = 0;
      mPage        = 0;
      mBlink       = 1'b0;
      mLevel       = 1'b0;
      mRisePending = 1'b0;
      btnHist.delete();
   endtask

   task automatic checkResetValues(input string pfx);
      checkOutput({pfx, "_an"}, {4'h0, an}, 8'h0F);
      checkOutput({pfx, "_seg"}, {1'b0, seg}, 8'h7F);
      checkOutput({pfx, "_dp"}, {7'h0, dp}, 8'h01);
      checkOutput({pfx, "_page"}, {6'h0, page}, 8'h00);
   endtask

   // One clock: predict the registered outputs from the pre-edge model state,
   // then advance the model and compare.
   task automatic stepCycle();
      logic [3:0] digs[4];
      int         idx;
      logic [6:0] eSeg;
      logic       eDp;
      logic [3:0] eAn;
      bit         allDiffer;
      bit         newRise;
      bit         s;
      @(posedge clk_100MHz);
      #1;
      if (reset) begin
         modelReset();
         checkResetValues("rst");
      end else begin
         edgeCount++;
         idx = ((edgeCount - 1) / REFRESH_DIV) % 4;
         case (mPage)
            0:       digs = '{min_1s, min_10s, hr_1s, hr_10s};
            1:       digs = '{sec_1s, sec_10s, min_1s, min_10s};
            2:       digs = '{d_1s, d_10s, m_1s, m_10s};
            default: digs = '{y_1s, y_10s, c_1s, c_10s};
         endcase
         eSeg = (mPage == 0 && idx == 3 && hr_10s == 4'd0) ? 7'h7F : segOf(digs[idx]);
         eDp  = !((idx == 2 && mPage <= 1 && mBlink) || (idx == 0 && mPage == 0 && am_pm)
                  || (idx == 2 && mPage == 2));
         eAn  = ~(4'b0001 << idx);

         btnHist.push_front(btn_page);
         allDiffer = 1'b1;
         newRise   = 1'b0;
         for (int j = 2; j <= DEBOUNCE_CYCLES + 1; j++) begin
            s = (j < btnHist.size()) ? btnHist[j] : 1'b0;
            if (s == mLevel) allDiffer = 1'b0;
         end
         if (allDiffer) begin
            mLevel  = !mLevel;
            newRise = mLevel;
         end
         if (btnHist.size() > DEBOUNCE_CYCLES + 2) void'(btnHist.pop_back());
         if (mRisePending) mPage = (mPage + 1) % 4;
         mRisePending = newRise;
         if (tick_1Hz) mBlink = !mBlink;

         checkOutput("an", {4'h0, an}, {4'h0, eAn});
         checkOutput("seg", {1'b0, seg}, {1'b0, eSeg});
         checkOutput("dp", {7'h0, dp}, {7'h0, eDp});
         checkOutput("page", {6'h0, page}, 8'(mPage));
      end
   endtask

   task automatic applyStimulus();
      if ($urandom_range(0, 2) == 0) begin
         hr_10s  = 4'($urandom_range(0, 2));
         hr_1s   = randDigit();
         min_10s = randDigit();
         min_1s  = randDigit();
         sec_10s = randDigit();
         sec_1s  = randDigit();
         m_10s   = randDigit();
         m_1s    = randDigit();
         d_10s   = randDigit();
         d_1s    = randDigit();
         y_10s   = randDigit();
         y_1s    = randDigit();
         c_10s   = randDigit();
         c_1s    = randDigit();
      end
      tick_1Hz = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 9) == 0) am_pm = !am_pm;
      // Button alternates between runs of 1..20 cycles: short runs are bounce.
      if (btnLeft == 0) begin
         btn_page = !btn_page;
         btnLeft  = $urandom_range(1, 20);
      end
      btnLeft--;
   endtask

   initial begin
      hr_10s = 4'd1; hr_1s = 4'd2; min_10s = 4'd3; min_1s = 4'd4;
      sec_10s = 4'd5; sec_1s = 4'd6; am_pm = 1'b1;
      m_10s = 4'd0; m_1s = 4'd7; d_10s = 4'd2; d_1s = 4'd8;
      c_10s = 4'd2; c_1s = 4'd0; y_10s = 4'd2; y_1s = 4'd5;

      #2 reset = 1'b1;
      #1 checkResetValues("async_rst");
      repeat (3) stepCycle();
      reset = 1'b0;
      repeat (20) stepCycle();

      hr_10s = 4'd0; hr_1s = 4'd9; min_10s = 4'd0;
      repeat (20) stepCycle();

      // Clean presses: four of them bring the page back round.
      for (int p = 0; p < 4; p++) begin
         btn_page = 1'b1;
         repeat (14) stepCycle();
         btn_page = 1'b0;
         repeat (14) stepCycle();
      end
      checkOutput("page_wrap", {6'h0, page}, 8'h00);

      for (int c = 0; c < 3000; c++) begin
         applyStimulus();
         stepCycle();
      end

      btn_page = 1'b0;
      tick_1Hz = 1'b0;
      repeat (15) stepCycle();
      btn_page = 1'b1;
      repeat (7) stepCycle();
      #3 reset = 1'b1;
      btn_page = 1'b0;
      #1 checkResetValues("mid_rst");
      modelReset();
      repeat (3) stepCycle();
      reset = 1'b0;
      repeat (30) stepCycle();
      checkOutput("page_after_rst", {6'h0, page}, 8'h00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/clock_display_scanner.md
# clock_display_scanner

Consumes the BCD digit, AM/PM and 1 Hz tick outputs of the clock/calendar top and drives the Basys3 4-digit, active-low, common-anode 7-segment display. Time-multiplexes four digits and selects one of four display pages (HH:MM, MM:SS, MM.DD, CCYY) with a debounced page button. Blinks the colon point from the 1 Hz tick. Sits between the clock/calendar top and the board pins.

## Interface
Parameters:
- REFRESH_DIV, 100000: clk cycles per digit slot (1 ms at 100 MHz); minimum 2.
- DEBOUNCE_CYCLES, 1000000: cycles the synchronized button must be stable (10 ms); minimum 2.

Ports:
- clk_100MHz  in  1  system clock; the only clock.
- reset  in  1  asynchronous, active-high reset.
- tick_1Hz  in  1  one-cycle pulse, once per second.
- am_pm  in  1  1 = PM.
- hr_10s, hr_1s, min_10s, min_1s, sec_10s, sec_1s  in  4 each  BCD time digits.
- m_10s, m_1s, d_10s, d_1s, y_10s, y_1s, c_10s, c_1s  in  4 each  BCD date digits.
- btn_page  in  1  raw asynchronous pushbutton, 1 = pressed.
- seg  out  7  cathodes, active low, seg[0]=a … seg[6]=g.
- dp  out  1  decimal point, active low.
- an  out  4  anodes, active low, an[0] = rightmost digit.
- page  out  2  current page, for LEDs and debug.

## Operation
- Page FSM states: PG_HM=0, PG_MS=1, PG_MD=2, PG_CY=3.
  - Each debounced press, counted on the rising edge of the debounced level, advances the page by one. PG_CY wraps to PG_HM.
  - Holding the button gives exactly one advance; there is no auto-repeat.
- Digit mapping, listed as an[3], an[2], an[1], an[0]:
  - PG_HM: hr_10s, hr_1s, min_10s, min_1s.
  - PG_MS: min_10s, min_1s, sec_10s, sec_1s.
  - PG_MD: m_10s, m_1s, d_10s, d_1s.
  - PG_CY: c_10s, c_1s, y_10s, y_1s.
- Leading-zero blanking applies only in PG_HM: an[3] shows blank (seg=0x7F) when hr_10s==0.
- Decimal points:
  - PG_HM and PG_MS: dp on digit 2 is lit while blink=1.
  - PG_HM only: dp on digit 0 is lit when am_pm=1.
  - PG_MD: dp on digit 2 is lit steadily.
  - PG_CY: all dp off.
- blink register toggles on every tick_1Hz, giving a 0.5 Hz square wave. A tick arriving in the same cycle as a page change still toggles blink.
- Segment codes are given as hex of {g..a}, active low:
  - 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19
  - 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10
  - Invalid BCD 10–15 displays a dash, 0x3F.
- Button path: 2-FF synchronizer, then a stability counter. The debounced level changes only after the synchronized input has differed from it for DEBOUNCE_CYCLES consecutive cycles. Any bounce clears the counter.

## Timing
- Refresh counter runs 0..REFRESH_DIV-1. On terminal count it returns to 0 and digit index advances 0→1→2→3→0.
- an, seg and dp are registered and change together one cycle after the index/page/input change. Exactly one anode is low at any time after the first post-reset update.
- Digit inputs are sampled every cycle; no latching. An input change is visible on the next register update while its digit is selected.
- Page changes one cycle after the debounced rising edge. The new page shows on the currently selected digit from the following cycle; the refresh counter is not reset.
- Press-to-page latency: 2 synchronizer cycles + DEBOUNCE_CYCLES + 1.
- Reset (asynchronous, any time, including mid-debounce) forces:
  - an=0xF, seg=0x7F, dp=1
  - page=PG_HM, digit index 0, refresh counter 0
  - blink=0, debounced level 0, debounce counter 0, synchronizer 0
- First anode (an=0xE) asserts on the first clock after reset release.

## Structure
- Package clock_display_pkg holds:
  - page encodings PG_HM/PG_MS/PG_MD/PG_CY;
  - segment constants SEG_BLANK=0x7F and SEG_DASH=0x3F;
  - a BCD-to-segment function.
- Sub-module button_debouncer (param DEBOUNCE_CYCLES) contains the synchronizer, counter and rising-edge pulse output. It is reusable for the inc_* buttons.
- Top contains the refresh counter, digit index, page FSM, blink register, mux and output registers.

## Test plan
All scenarios use REFRESH_DIV=4 and DEBOUNCE_CYCLES=8.
1. Reset held, then released with time 12:34:56 PM -> during reset an=0xF, seg=0x7F, dp=1. After release an cycles E,D,B,7 every 4 cycles; seg shows 0x19, 0x30, 0x24, 0x79; digit 0 dp=0.
2. hr_10s=0, hr_1s=9, PG_HM -> an=0x7 slot gives seg=0x7F. The same value in PG_MS (min_10s=0) gives 0x40.
3. btn_page high for 12 cycles with a 2-cycle bounce at cycle 3 -> a single page increment, occurring 2+8+1 cycles after the last bounce. Four clean presses return page to 0.
4. tick_1Hz pulsed 3 times in PG_MS -> blink 0→1→0→1. Digit 2 dp follows it and is low after the third tick.
5. m_1s=4'hB in PG_MD -> an=0xB slot shows seg=0x3F; digit 2 dp is steadily low.
6. Reset asserted mid-debounce (counter=5) and mid-slot -> outputs go to their reset values within the same cycle. page stays 0 after release, with no spurious advance.
